md_unit_sched: RTL and testbench

//  Multi-cycle multiply/divide resource and its scheduler for the 5-stage pipeline.

---
 rtl/md_unit_sched.sv | 150 +++++++++++++++
 tb/tb_md_unit_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_sched.sv
// Purpose: multi-cycle multiply/divide unit with HI/LO and D-stage stall request.
// Latency: start at cycle T -> busy T+1..T+N (N = MULT_CYC or DIV_CYC), HI/LO updated from T+N+1.
// Backpressure: stallReq holds D while a HI/LO user meets a busy unit; starts during RUN are dropped.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start, mdOp      E-stage MD op valid and its opcode (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   src1, src2       forwarded rs/rt operands
//   D_mdUse          D-stage instruction touches HI/LO or the MD unit
//   busy             unit is computing
//   stallReq         combinational stall request for the pipeline freeze
//   hi, lo           architectural HI/LO registers
module md_unit_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        D_mdUse,
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [31:0]    opA;
  logic [31:0]    opB;
  logic [2:0]     opCode;

  logic           startLong;
  logic [63:0]    sProd;
  logic [63:0]    uProd;
  logic [63:0]    opA64s;
  logic [63:0]    opB64s;
  logic [31:0]    resHi;
  logic [31:0]    resLo;

  assign startLong = start & (mdOp >= OP_MULT) & (mdOp <= OP_DIVU);

  // busy covers the whole RUN window; the start term covers the cycle
  // before busy rises so the D stage never slips past a pending op.
  assign stallReq = D_mdUse & (busy | startLong);

  // Sign-extend to 64 bits so the low 64 bits of the product are the
  // exact signed result.
  assign opA64s = {{32{opA[31]}}, opA};
  assign opB64s = {{32{opB[31]}}, opB};
  assign sProd  = opA64s * opB64s;
  assign uProd  = {32'd0, opA} * {32'd0, opB};

  // Result is derived from the latched operands only; it is consumed on
  // the final RUN edge. Divide by zero falls through to the current HI/LO
  // so the write-back leaves them unchanged.
  always_comb begin
    resHi = hi;
    resLo = lo;
    case (opCode)
      OP_MULT: begin
        resHi = sProd[63:32];
        resLo = sProd[31:0];
      end
      OP_MULTU: begin
        resHi = uProd[63:32];
        resLo = uProd[31:0];
      end
      OP_DIV: begin
        if (opB != 32'd0) begin
          resLo = $signed(opA) / $signed(opB);
          resHi = $signed(opA) % $signed(opB);
        end
      end
      OP_DIVU: begin
        if (opB != 32'd0) begin
          resLo = opA / opB;
          resHi = opA % opB;
        end
      end
      default: begin
        resHi = hi;
        resLo = lo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      count  <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opA    <= 32'd0;
      opB    <= 32'd0;
      opCode <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (startLong) begin
            opA    <= src1;
            opB    <= src2;
            opCode <= mdOp;
            count  <= ((mdOp == OP_MULT) || (mdOp == OP_MULTU)) ? CW'(MULT_CYC) : CW'(DIV_CYC);
            busy   <= 1'b1;
            state  <= RUN;
          end else if (start && (mdOp == OP_MTHI)) begin
            hi <= src1;
          end else if (start && (mdOp == OP_MTLO)) begin
            lo <= src1;
          end
        end
        RUN: begin
          // Any start arriving here is ignored: the stall keeps it from
          // happening in a correct pipeline.
          if (count == CW'(1)) begin
            hi    <= resHi;
            lo    <= resLo;
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_sched.sv
// Purpose: self-checking bench for md_unit_sched against a cycle-indexed reference model.
// Latency: one compare set per clock cycle, sampled 1 time unit after the falling edge.
// Backpressure: none modelled; stimulus deliberately issues starts while the unit is busy.
module tb_md_unit_sched;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        D_mdUse;
  logic        busy;
  logic        stallReq;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdOp     (mdOp),
    .src1     (src1),
    .src2     (src2),
    .D_mdUse  (D_mdUse),
    .busy     (busy),
    .stallReq (stallReq),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle index and the last cycle of the
  // current operation; results are committed when that cycle ends.
  int          cyc;
  int          doneCyc;
  logic [31:0] mHi;
  logic [31:0] mLo;
  logic [31:0] pHi;
  logic [31:0] pLo;
  bit          pWrite;

  logic        obsBusy;
  logic        obsStall;
  int          bc;
  int          sc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic computeResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      na, nb, qa, q, r;
    logic [63:0] x, y, p;
    pWrite = 1'b1;
    case (op)
      OP_MULT: begin
        p   = 64'(longint'($signed(a)) * longint'($signed(b)));
        pHi = p[63:32];
        pLo = p[31:0];
      end
      OP_MULTU: begin
        x   = {32'd0, a};
        y   = {32'd0, b};
        p   = x * y;
        pHi = p[63:32];
        pLo = p[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) pWrite = 1'b0;
        else begin
          na = longint'($signed(a));
          nb = longint'($signed(b));
          qa = (na < 0 ? -na : na) / (nb < 0 ? -nb : nb);
          q  = ((na < 0) != (nb < 0)) ? -qa : qa;
          r  = na - q * nb;
          pLo = q[31:0];
          pHi = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) pWrite = 1'b0;
        else begin
          na = longint'({32'd0, a});
          nb = longint'({32'd0, b});
          q  = na / nb;
          r  = na - q * nb;
          pLo = q[31:0];
          pHi = r[31:0];
        end
      end
    endcase
  endtask

  // One clock cycle: drive inputs, compare, then advance the model across
  // the coming rising edge.
  task automatic cycle(input bit r, input bit st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit du);
    bit expBusy, stLong, expStall;
    @(negedge clk);
    reset = r; start = st; mdOp = op; src1 = a; src2 = b; D_mdUse = du;
    #1;
    expBusy  = (cyc <= doneCyc);
    stLong   = st && (op >= OP_MULT) && (op <= OP_DIVU);
    expStall = du && (expBusy || stLong);
    obsBusy  = busy;
    obsStall = stallReq;
    chk("busy", 32'(busy), 32'(expBusy));
    chk("stallReq", 32'(stallReq), 32'(expStall));
    chk("hi", hi, mHi);
    chk("lo", lo, mLo);
    if (r) begin
      mHi = 32'd0;
      mLo = 32'd0;
      doneCyc = -1;
    end else if (expBusy) begin
      if (cyc == doneCyc && pWrite) begin
        mHi = pHi;
        mLo = pLo;
      end
    end else if (st) begin
      case (op)
        OP_MULT, OP_MULTU: begin computeResult(op, a, b); doneCyc = cyc + MULT_CYC; end
        OP_DIV, OP_DIVU:   begin computeResult(op, a, b); doneCyc = cyc + DIV_CYC; end
        OP_MTHI: mHi = a;
        OP_MTLO: mLo = a;
        default: ;
      endcase
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit du);
    bc = 0;
    sc = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, OP_NONE, $urandom, $urandom, du);
      bc += int'(obsBusy);
      sc += int'(obsStall);
    end
  endtask

  initial begin
    bit          rr, st, du;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; mdOp = OP_NONE; src1 = 32'd0; src2 = 32'd0; D_mdUse = 1'b0;
    repeat (2) @(posedge clk);
    cyc = 0; doneCyc = -1; mHi = 32'd0; mLo = 32'd0; pHi = 32'd0; pLo = 32'd0; pWrite = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
    chk("rst_busy", 32'(obsBusy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // mult 3 * -4 with D-stage user present
    cycle(1'b0, 1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFC, 1'b1);
    chk("mult_stall_start", 32'(obsStall), 32'd1);
    idle(5, 1'b1);
    chk("mult_busy_len", bc, 32'd5);
    chk("mult_stall_len", sc, 32'd5);
    chk("mult_hi_T5", hi, 32'd0);
    chk("mult_lo_T5", lo, 32'd0);
    idle(1, 1'b1);
    chk("mult_stall_T6", 32'(obsStall), 32'd0);
    chk("mult_hi_T6", hi, 32'hFFFF_FFFF);
    chk("mult_lo_T6", lo, 32'hFFFF_FFF4);

    // multu
    cycle(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(6, 1'b0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div 7 / -2
    cycle(1'b0, 1'b1, OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    idle(11, 1'b0);
    chk("div_busy_len", bc, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'd1);

    // divu by zero keeps prior HI/LO
    cycle(1'b0, 1'b1, OP_MTHI, 32'd5, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, OP_MTLO, 32'd9, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
    idle(11, 1'b0);
    chk("divu0_busy_len", bc, 32'd10);
    chk("divu0_hi", hi, 32'd5);
    chk("divu0_lo", lo, 32'd9);

    // mtlo during a busy mult is dropped
    cycle(1'b0, 1'b1, OP_MULT, 32'd2, 32'd3, 1'b0);
    cycle(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, OP_MTLO, 32'd8, 32'd0, 1'b0);
    idle(4, 1'b0);
    chk("busy_mtlo_lo", lo, 32'd6);
    chk("busy_mtlo_hi", hi, 32'd0);

    // mthi single cycle
    cycle(1'b0, 1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0);
    chk("mthi_busy_start", 32'(obsBusy), 32'd0);
    idle(1, 1'b0);
    chk("mthi_busy_next", bc, 32'd0);
    chk("mthi_hi", hi, 32'h1234);

    // reset at T+3 of a divide
    cycle(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
    idle(1, 1'b1);
    chk("rstdiv_busy", 32'(obsBusy), 32'd0);
    chk("rstdiv_stall", 32'(obsStall), 32'd0);
    chk("rstdiv_hi", hi, 32'd0);
    chk("rstdiv_lo", lo, 32'd0);

    // Randomized traffic, including starts during RUN and mid-op resets
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 9) < 4);
      du = $urandom_range(0, 1) == 1;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      cycle(rr, st, op, a, b, du);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
